aes_block_loader: RTL and testbench

Front-end control stage for the AES encrypt/decrypt pair. It accepts a byte stream (ready/valid) and packs 16 bytes into a 128-bit block. It drives that block on `text_in`, then sequences the `en_start`, `de_start` and `out_en` controls of the AES top so that each block is encrypted, decrypted and both results are presented in turn. It sits between the byte source (UART RX or test stimulus) and the AES top.

---
 rtl/aes_ctrl_pkg.sv | 9 +
 rtl/aes_block_loader_if.sv | 22 ++
 rtl/aes_byte_packer.sv | 27 ++
 rtl/aes_block_loader.sv | 94 +++++++++
 tb/tb_aes_block_loader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES block loader
package aes_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ENC, DEC, DONE} state_t;
    localparam int BLK_BYTES = 16;
    localparam int BLK_W = 128;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: byte stream in, AES block and control out
interface aes_block_loader_if;
    import aes_ctrl_pkg::*;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic [BLK_W-1:0] text_in;
    logic en_start;
    logic de_start;
    logic out_en;
    logic busy;
    logic blk_done;
    logic err;
    modport master (
        output rx_data, rx_valid,
        input rx_ready, text_in, en_start, de_start, out_en, busy, blk_done, err
    );
    modport slave (
        input rx_data, rx_valid,
        output rx_ready, text_in, en_start, de_start, out_en, busy, blk_done, err
    );
endinterface

// File: rtl/aes_byte_packer.sv
// aes_byte_packer: shifts bytes into a 128-bit block, first byte ends up in the top byte
module aes_byte_packer
    import aes_ctrl_pkg::*;
(
    input logic sys_clk,
    input logic sys_rst,
    input logic clr,
    input logic load,
    input logic [7:0] data,
    output logic [BLK_W-1:0] text,
    output logic full
);
    logic [3:0] count;
    // count wraps 15->0 on the 16th load, which is exactly block completion
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            text <= '0;
            count <= '0;
        end else if (load) begin
            text <= {text[BLK_W-9:0], data};
            count <= count + 1'b1;
        end else if (clr) begin
            count <= '0;
        end
    end
    assign full = count == 4'(BLK_BYTES - 1);
endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: packs 16 bytes into a block, then sequences AES encrypt and decrypt
module aes_block_loader
    import aes_ctrl_pkg::*;
#(
    parameter int ENC_LAT = 12,
    parameter int DEC_LAT = 12,
    parameter int TIMEOUT = 1000
) (
    input logic sys_clk,
    input logic sys_rst,
    aes_block_loader_if.slave bus
);
    localparam int WW = $clog2(max_int(ENC_LAT, DEC_LAT) + 1);
    localparam int TW = $clog2(max_int(TIMEOUT, 1) + 1);
    // decided one cycle early so the registered err lands TIMEOUT cycles after the last byte
    localparam int TO_HIT = TIMEOUT > 1 ? TIMEOUT - 2 : 0;
    state_t state;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    logic xfer, full, tmo;
    assign xfer = bus.rx_valid && bus.rx_ready;
    assign tmo = state == LOAD && !xfer && TIMEOUT != 0 && tcnt == TW'(TO_HIT);
    aes_byte_packer u_packer (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clr(tmo),
        .load(xfer),
        .data(bus.rx_data),
        .text(bus.text_in),
        .full(full)
    );
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            wcnt <= '0;
            tcnt <= '0;
            bus.rx_ready <= 1'b1;
            bus.en_start <= 1'b0;
            bus.de_start <= 1'b0;
            bus.out_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.blk_done <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.en_start <= 1'b0;
            bus.de_start <= 1'b0;
            bus.blk_done <= 1'b0;
            bus.err <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    state <= LOAD;
                    tcnt <= '0;
                end
                LOAD: if (xfer && full) begin
                    state <= ENC;
                    wcnt <= '0;
                    bus.rx_ready <= 1'b0;
                    bus.busy <= 1'b1;
                    bus.out_en <= 1'b1;
                    bus.en_start <= 1'b1;
                end else if (xfer) begin
                    tcnt <= '0;
                end else if (tmo) begin
                    state <= IDLE;
                    tcnt <= '0;
                    bus.err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                ENC: if (wcnt == WW'(ENC_LAT - 1)) begin
                    state <= DEC;
                    wcnt <= '0;
                    bus.out_en <= 1'b0;
                    bus.de_start <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                DEC: if (wcnt == WW'(DEC_LAT - 1)) begin
                    state <= DONE;
                    wcnt <= '0;
                    bus.blk_done <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    bus.rx_ready <= 1'b1;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: random and directed byte streams against a cycle-schedule reference model
module tb_aes_block_loader;
    import aes_ctrl_pkg::*;
    localparam int E = 12;
    localparam int D = 12;
    localparam int TO = 20;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    aes_block_loader_if bus();
    aes_block_loader #(.ENC_LAT(E), .DEC_LAT(D), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n16 = -1000;
    int lastx = 0;
    bit err_exp = 0;
    bit text_known = 1;
    logic [7:0] part[$];
    logic [127:0] exp_text = '0;
    int oe_run = 0;
    int rl_run = 0;
    int oe_runs[$];
    int rl_runs[$];
    int ac;
    int n;
    bit took;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // busy window of the most recent block: from the cycle after its 16th byte through DONE
    function automatic bit in_busy(input int c);
        return c >= n16 + 1 && c <= n16 + 1 + E + D;
    endfunction

    task automatic check_outputs();
        chk("rx_ready", bus.rx_ready, !in_busy(cyc));
        chk("busy", bus.busy, in_busy(cyc));
        chk("en_start", bus.en_start, cyc == n16 + 1);
        chk("out_en", bus.out_en, cyc >= n16 + 1 && cyc <= n16 + E);
        chk("de_start", bus.de_start, cyc == n16 + 1 + E);
        chk("blk_done", bus.blk_done, cyc == n16 + 1 + E + D);
        chk("err", bus.err, err_exp);
        if (text_known && part.size() == 0) chk("text_in", bus.text_in, exp_text);
    endtask

    task automatic tick(input logic v, input logic [7:0] d, output bit t);
        bus.rx_valid = v;
        bus.rx_data = d;
        t = v && !in_busy(cyc);
        @(posedge sys_clk);
        #1;
        if (t) begin
            part.push_back(d);
            lastx = cyc;
            if (part.size() == 16) begin
                exp_text = '0;
                foreach (part[k]) exp_text |= 128'(part[k]) << (8 * (15 - k));
                part.delete();
                n16 = cyc;
                text_known = 1;
            end
        end
        cyc++;
        err_exp = part.size() > 0 && cyc == lastx + TO;
        if (err_exp) begin
            part.delete();
            text_known = 0;
        end
        check_outputs();
        if (!bus.rx_ready) rl_run++;
        else if (rl_run > 0) begin
            rl_runs.push_back(rl_run);
            rl_run = 0;
        end
        if (bus.out_en) oe_run++;
        else if (oe_run > 0) begin
            oe_runs.push_back(oe_run);
            oe_run = 0;
        end
    endtask

    task automatic idle(input int cnt);
        bit t;
        repeat (cnt) tick(1'b0, 8'($urandom), t);
    endtask

    // mode 0: continuous valid, 1: one idle cycle before each byte, 2: random valid
    task automatic send_byte(input logic [7:0] d, input int mode);
        bit t = 0;
        int k = 0;
        if (mode == 1) tick(1'b0, d, t);
        while (!t && k < 100) begin
            tick(mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1, d, t);
            k++;
        end
        total++;
        assert (t) else begin
            bad++;
            $error("FAIL send: byte %0h not accepted, got 0 want 1", d);
        end
    endtask

    task automatic send_rand_block(input int mode);
        repeat (16) send_byte(8'($urandom), mode);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        @(posedge sys_clk);
        #1;
        check_outputs();
        sys_rst = 1'b0;

        for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 0);
        idle(30);
        chk("blk1_text", bus.text_in, 128'h00112233445566778899aabbccddeeff);

        for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1);
        idle(30);
        chk("blk2_text", bus.text_in, 128'h00112233445566778899aabbccddeeff);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        n = 0;
        repeat (TO + 5) begin
            idle(1);
            if (bus.err) n++;
        end
        chk("err_count", 128'(n), 128'd1);
        repeat (16) send_byte(8'hA5, 0);
        idle(30);
        chk("a5_text", bus.text_in, {16{8'hA5}});

        send_rand_block(0);
        n = 0;
        do begin
            ac = cyc;
            tick(1'b1, 8'h3C, took);
            n++;
        end while (!took && n < 100);
        chk("hold_accept_cycle", 128'(ac), 128'(n16 + 2 + E + D));
        repeat (15) send_byte(8'($urandom), 0);
        idle(30);
        chk("hold_byte0", bus.text_in[127:120], 8'h3C);

        send_rand_block(2);
        while (cyc < n16 + 1 + E + 3) idle(1);
        #2;
        sys_rst = 1'b1;
        #1;
        n16 = -1000;
        part.delete();
        exp_text = '0;
        text_known = 1;
        err_exp = 0;
        check_outputs();
        @(posedge sys_clk);
        #1;
        cyc++;
        check_outputs();
        sys_rst = 1'b0;
        send_rand_block(2);
        idle(30);

        oe_runs.delete();
        rl_runs.delete();
        send_rand_block(0);
        send_rand_block(0);
        idle(30);
        chk("oe_runs", 128'(oe_runs.size()), 128'd2);
        chk("rl_runs", 128'(rl_runs.size()), 128'd2);
        foreach (oe_runs[i]) chk("out_en_len", 128'(oe_runs[i]), 128'(E));
        foreach (rl_runs[i]) chk("ready_low_len", 128'(rl_runs[i]), 128'(E + D + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
